forward_ctrl_unit: RTL and testbench

FORWARD_CTRL_UNIT -- requirements
Module: forward_ctrl_unit

---
 rtl/fwd_pkg.sv | 26 ++
 rtl/fwd_select.sv | 21 ++
 rtl/forward_ctrl_unit.sv | 59 +++++
 tb/tb_forward_ctrl_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: operand-select encodings and shadow pipeline stage types
package fwd_pkg;
  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [4:0] REG_ZERO  = 5'd0;
  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } ex_stage_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } mem_stage_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
  } wb_stage_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: picks the bypass source for one EX operand, EX/MEM over MEM/WB
module fwd_select
  import fwd_pkg::*;
(
  input  logic       ex_valid,
  input  logic [4:0] src,
  input  logic       mem_valid,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_rd,
  input  logic       wb_valid,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_rd,
  output logic [1:0] sel
);
  logic mem_hit, wb_hit;
  always_comb begin
    mem_hit = mem_valid && mem_regwrite && mem_rd != REG_ZERO && mem_rd == src;
    wb_hit  = wb_valid && wb_regwrite && wb_rd != REG_ZERO && wb_rd == src;
    sel     = !ex_valid ? FWD_IDEX : mem_hit ? FWD_EXMEM : wb_hit ? FWD_MEMWB : FWD_IDEX;
  end
endmodule

// File: rtl/forward_ctrl_unit.sv
// forward_ctrl_unit: shadow-pipeline forwarding selects and load-use stall control
module forward_ctrl_unit
  import fwd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_rt_used,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        stall,
  output logic [15:0] stall_count
);
  ex_stage_t  ex;
  mem_stage_t mem;
  wb_stage_t  wb;
  logic [15:0] cnt;
  logic load_hit;
  always_comb begin
    load_hit = ex.valid && ex.memread && ex.rd != REG_ZERO &&
               (ex.rd == id_rs || (id_rt_used && ex.rd == id_rt));
    stall    = id_valid && !flush && load_hit;
  end
  // flush and stall both turn the EX slot into a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
      cnt <= '0;
    end else begin
      ex  <= (id_valid && !stall && !flush) ?
             ex_stage_t'{valid: 1'b1, rs: id_rs, rt: id_rt, rd: id_rd,
                         regwrite: id_regwrite, memread: id_memread} : '0;
      mem <= mem_stage_t'{valid: ex.valid, rd: ex.rd, regwrite: ex.regwrite, memread: ex.memread};
      wb  <= wb_stage_t'{valid: mem.valid, rd: mem.rd, regwrite: mem.regwrite};
      cnt <= (stall && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    end
  end
  assign stall_count = cnt;
  fwd_select u_sel_a (
    .ex_valid(ex.valid), .src(ex.rs),
    .mem_valid(mem.valid), .mem_regwrite(mem.regwrite), .mem_rd(mem.rd),
    .wb_valid(wb.valid), .wb_regwrite(wb.regwrite), .wb_rd(wb.rd),
    .sel(fwd_a)
  );
  fwd_select u_sel_b (
    .ex_valid(ex.valid), .src(ex.rt),
    .mem_valid(mem.valid), .mem_regwrite(mem.regwrite), .mem_rd(mem.rd),
    .wb_valid(wb.valid), .wb_regwrite(wb.regwrite), .wb_rd(wb.rd),
    .sel(fwd_b)
  );
endmodule

// File: tb/tb_forward_ctrl_unit.sv
// tb_forward_ctrl_unit: directed instruction sequences with hand-computed selects and stalls
module tb_forward_ctrl_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_rt_used, id_regwrite, id_memread, flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall;
  logic [15:0] stall_count;
  int vectors = 0;
  int errs = 0;

  forward_ctrl_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rtu, input logic [4:0] rd, input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_rt_used  = rtu;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    #1;
  endtask

  task automatic nop;
    id_set(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain;
    nop();
    repeat (3) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    nop();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_fwd_a", {14'd0, fwd_a}, 16'h0);
    chk("reset_fwd_b", {14'd0, fwd_b}, 16'h0);
    chk("reset_stall", {15'd0, stall}, 16'h0);
    chk("reset_count", stall_count, 16'h0);

    // back-to-back: add r3,r1,r2 ; sub r5,r3,r4
    id_set(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0);
    chk("b2b_stall", {15'd0, stall}, 16'h0);
    tick();
    chk("b2b_fwd_a", {14'd0, fwd_a}, 16'h2);
    chk("b2b_fwd_b", {14'd0, fwd_b}, 16'h0);
    drain();

    // distance 2: add r3 ; nop ; or r6,r3,r3
    id_set(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    id_set(1'b1, 5'd3, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    chk("d2_fwd_a", {14'd0, fwd_a}, 16'h1);
    chk("d2_fwd_b", {14'd0, fwd_b}, 16'h1);
    drain();

    // double hit: add r3 ; add r3 ; and r7,r3,r1 -> EX/MEM wins
    id_set(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 5'd3, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    chk("dbl_fwd_a", {14'd0, fwd_a}, 16'h2);
    chk("dbl_fwd_b", {14'd0, fwd_b}, 16'h0);
    drain();

    // load-use: lw r2,0(r1) ; add r4,r2,r1
    id_set(1'b1, 5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    id_set(1'b1, 5'd2, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0);
    chk("lu_stall1", {15'd0, stall}, 16'h1);
    tick();
    chk("lu_stall2", {15'd0, stall}, 16'h0);
    chk("lu_count", stall_count, 16'h1);
    chk("lu_bubble_a", {14'd0, fwd_a}, 16'h0);
    tick();
    chk("lu_fwd_a", {14'd0, fwd_a}, 16'h1);
    chk("lu_fwd_b", {14'd0, fwd_b}, 16'h0);
    chk("lu_stall3", {15'd0, stall}, 16'h0);
    drain();

    // lw r0 ; add r4,r0,r0 -> no stall, no forward
    id_set(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    id_set(1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    chk("r0_stall", {15'd0, stall}, 16'h0);
    tick();
    chk("r0_fwd_a", {14'd0, fwd_a}, 16'h0);
    chk("r0_fwd_b", {14'd0, fwd_b}, 16'h0);
    drain();

    // flush beats hazard; flushed lw r5 must not reach EX
    id_set(1'b1, 5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    id_set(1'b1, 5'd2, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    flush = 1'b1;
    #1;
    chk("fl_stall", {15'd0, stall}, 16'h0);
    tick();
    flush = 1'b0;
    id_set(1'b1, 5'd5, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    chk("fl_bubble", {15'd0, stall}, 16'h0);
    chk("fl_count", stall_count, 16'h1);
    drain();

    // saturation: preload counter near the top, then keep stalling
    force dut.cnt = 16'hFFFA;
    #1;
    release dut.cnt;
    id_set(1'b1, 5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    repeat (20) tick();
    chk("sat_count", stall_count, 16'hFFFF);
    repeat (4) tick();
    chk("sat_hold", stall_count, 16'hFFFF);
    drain();

    // reset during a load-use stall
    id_set(1'b1, 5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    id_set(1'b1, 5'd2, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0);
    chk("rs_stall_pre", {15'd0, stall}, 16'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rs_stall", {15'd0, stall}, 16'h0);
    chk("rs_fwd_a", {14'd0, fwd_a}, 16'h0);
    chk("rs_fwd_b", {14'd0, fwd_b}, 16'h0);
    chk("rs_count", stall_count, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
